matrix_mul2x2: RTL and testbench

Sequential 2x2 matrix multiplier for Q2.14 signed operands, computing P = X·Y with one shared 16x16 multiplier and a 33-bit accumulator. It closes the loop on the matrix inversion datapath: it multiplies a matrix by its computed inverse so the result can be checked against identity, and it also serves any block that needs a 2x2 product. Operands arrive over a valid/ready input handshake. Results leave over a valid/ready output handshake, with saturation and an overflow flag.

---
 rtl/matrix_mul2x2.sv | 141 ++++++++++++++
 tb/tb_matrix_mul2x2.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/matrix_mul2x2.sv
// Sequential 2x2 Q2.14 matrix multiplier: one shared 16x16 multiplier, 33-bit
// accumulator, round-half-up and saturation, valid/ready on both sides.
module matrix_mul2x2 (
  input  logic               clk,
  input  logic               reset,
  input  logic signed [15:0] xa,
  input  logic signed [15:0] xb,
  input  logic signed [15:0] xc,
  input  logic signed [15:0] xd,
  input  logic signed [15:0] ya,
  input  logic signed [15:0] yb,
  input  logic signed [15:0] yc,
  input  logic signed [15:0] yd,
  input  logic               in_valid,
  output logic               in_ready,
  output logic signed [15:0] pa,
  output logic signed [15:0] pb,
  output logic signed [15:0] pc,
  output logic signed [15:0] pd,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               overflow,
  output logic [1:0]         dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both 1;
  // in_ready is high only in IDLE, out_valid only in DONE, so they never overlap.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic [2:0]         r_step;
  logic signed [15:0] r_x [0:3];
  logic signed [15:0] r_y [0:3];
  logic signed [32:0] r_acc;
  logic signed [15:0] r_pa, r_pb, r_pc, r_pd;
  logic               r_out_valid;
  logic               r_ovf;

  logic signed [15:0] w_xop;
  logic signed [15:0] w_yop;
  logic signed [31:0] w_prod;
  logic signed [32:0] w_prod_ext;
  logic signed [32:0] w_sum;
  logic signed [32:0] w_shift;
  logic               w_sat_hi;
  logic               w_sat_lo;
  logic signed [15:0] w_res;

  // Step order xa*ya, xb*yc, xa*yb, xb*yd, xc*ya, xd*yc, xc*yb, xd*yd maps
  // directly onto step bits: X index {s2,s0}, Y index {s1,s0} with Y = {ya,yc,yb,yd}.
  assign w_xop      = r_x[{r_step[2], r_step[0]}];
  assign w_yop      = r_y[{r_step[1], r_step[0]}];
  assign w_prod     = w_xop * w_yop;
  assign w_prod_ext = {w_prod[31], w_prod};
  assign w_sum      = r_acc + w_prod_ext;
  assign w_shift    = (w_sum + 33'sd8192) >>> 14;
  assign w_sat_hi   = (w_shift > 33'sd32767);
  assign w_sat_lo   = (w_shift < -33'sd32768);

  always_comb begin
    w_res = w_shift[15:0];
    if (w_sat_hi) w_res = 16'sh7FFF;
    else if (w_sat_lo) w_res = -16'sh8000;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_step      <= 3'd0;
      r_acc       <= '0;
      r_pa        <= '0;
      r_pb        <= '0;
      r_pc        <= '0;
      r_pd        <= '0;
      r_out_valid <= 1'b0;
      r_ovf       <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        r_x[i] <= '0;
        r_y[i] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_x[0]  <= xa;
            r_x[1]  <= xb;
            r_x[2]  <= xc;
            r_x[3]  <= xd;
            r_y[0]  <= ya;
            r_y[1]  <= yc;
            r_y[2]  <= yb;
            r_y[3]  <= yd;
            r_acc   <= '0;
            r_step  <= 3'd0;
            r_ovf   <= 1'b0;
            r_state <= S_MAC;
          end
        end
        S_MAC: begin
          if (!r_step[0]) begin
            r_acc <= w_prod_ext;
          end else begin
            r_ovf <= r_ovf | w_sat_hi | w_sat_lo;
            case (r_step[2:1])
              2'd0:    r_pa <= w_res;
              2'd1:    r_pb <= w_res;
              2'd2:    r_pc <= w_res;
              default: r_pd <= w_res;
            endcase
          end
          r_step <= r_step + 3'd1;
          if (r_step == 3'd7) begin
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE) && !reset;
  assign out_valid = r_out_valid;
  assign overflow  = r_ovf;
  assign pa        = r_pa;
  assign pb        = r_pb;
  assign pc        = r_pc;
  assign pd        = r_pd;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_matrix_mul2x2.sv
// Directed bench for matrix_mul2x2: identity, inverse, mixed, saturation,
// rounding, output back-pressure and mid-job reset.
module tb_matrix_mul2x2;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic signed [15:0] xa = '0, xb = '0, xc = '0, xd = '0;
  logic signed [15:0] ya = '0, yb = '0, yc = '0, yd = '0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [15:0] pa, pb, pc, pd;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic               overflow;
  logic [1:0]         dbg_state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  matrix_mul2x2 dut (
    .clk(clk), .reset(reset),
    .xa(xa), .xb(xb), .xc(xc), .xd(xd),
    .ya(ya), .yb(yb), .yc(yc), .yd(yd),
    .in_valid(in_valid), .in_ready(in_ready),
    .pa(pa), .pb(pb), .pc(pc), .pd(pd),
    .out_valid(out_valid), .out_ready(out_ready),
    .overflow(overflow), .dbg_state(dbg_state)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic scramble_inputs();
    xa = 16'($urandom_range(0, 65535)); xb = 16'($urandom_range(0, 65535));
    xc = 16'($urandom_range(0, 65535)); xd = 16'($urandom_range(0, 65535));
    ya = 16'($urandom_range(0, 65535)); yb = 16'($urandom_range(0, 65535));
    yc = 16'($urandom_range(0, 65535)); yd = 16'($urandom_range(0, 65535));
  endtask

  // Presents operands for one cycle; returns at the falling edge after the accept edge.
  task automatic start_job(input string tag,
                           input logic signed [15:0] a, b, c, d, e, f, g, h);
    @(negedge clk);
    chk({tag, "_in_ready_idle"}, in_ready, 1);
    xa = a; xb = b; xc = c; xd = d;
    ya = e; yb = f; yc = g; yd = h;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    scramble_inputs();
    chk({tag, "_in_ready_busy"}, in_ready, 0);
  endtask

  task automatic wait_done(input string tag, input int exp_lat);
    int lat;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_out_valid"}, out_valid, 1);
    if (exp_lat > 0) chk({tag, "_latency"}, lat, exp_lat);
  endtask

  task automatic check_p(input string tag, input logic signed [15:0] ea, eb, ec, ed,
                         input logic eovf);
    chk({tag, "_pa"}, pa, ea);
    chk({tag, "_pb"}, pb, eb);
    chk({tag, "_pc"}, pc, ec);
    chk({tag, "_pd"}, pd, ed);
    chk({tag, "_overflow"}, overflow, eovf);
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_out_valid_low"}, out_valid, 0);
    chk({tag, "_in_ready_back"}, in_ready, 1);
  endtask

  task automatic run_job(input string tag,
                         input logic signed [15:0] a, b, c, d, e, f, g, h,
                         input logic signed [15:0] ea, eb, ec, ed, input logic eovf);
    start_job(tag, a, b, c, d, e, f, g, h);
    wait_done(tag, 8);
    check_p(tag, ea, eb, ec, ed, eovf);
    handshake(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    check_p("rst", 16'sd0, 16'sd0, 16'sd0, 16'sd0, 1'b0);
    reset = 1'b0;
    #1;
    chk("rst_release_in_ready", in_ready, 1);

    run_job("identity", 16384, 0, 0, 16384, 16384, 0, 0, 16384,
            16384, 0, 0, 16384, 1'b0);
    run_job("inverse", 16384, 8192, 0, 16384, 16384, -8192, 0, 16384,
            16384, 0, 0, 16384, 1'b0);
    // X=[0.5 0.25; -1 0.75], Y=[1 -0.5; 0.5 1] -> P=[0.625 0; -0.625 1.25]
    run_job("mixed", 8192, 4096, -16384, 12288, 16384, -8192, 8192, 16384,
            10240, 0, -10240, 20480, 1'b0);
    run_job("sat_pos", 24576, 24576, 24576, 24576, 24576, 24576, 24576, 24576,
            32767, 32767, 32767, 32767, 1'b1);
    run_job("sat_neg", 24576, 24576, 24576, 24576, -24576, -24576, -24576, -24576,
            -32768, -32768, -32768, -32768, 1'b1);
    run_job("ovf_clear", 16384, 0, 0, 16384, 16384, 0, 0, 16384,
            16384, 0, 0, 16384, 1'b0);
    run_job("round_up", 1, 0, 0, 0, 8192, 0, 0, 0, 1, 0, 0, 0, 1'b0);
    run_job("round_neg", 1, 0, 0, 0, -8192, 0, 0, 0, 0, 0, 0, 0, 1'b0);

    // Back-pressure: DONE holds with P stable while inputs toggle
    start_job("hold", 8192, 4096, -16384, 12288, 16384, -8192, 8192, 16384);
    wait_done("hold", 8);
    for (int i = 0; i < 5; i++) begin
      in_valid = ~in_valid;
      scramble_inputs();
      @(negedge clk);
      chk("hold_out_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
      check_p("hold", 10240, 0, -10240, 20480, 1'b0);
    end
    in_valid = 1'b0;
    handshake("hold");
    @(negedge clk);
    chk("hold_no_second_job", out_valid, 0);
    check_p("hold_after", 10240, 0, -10240, 20480, 1'b0);

    // Reset just before MAC step 4 executes
    start_job("midrst", 24576, 24576, 24576, 24576, 24576, 24576, 24576, 24576);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready_held", in_ready, 0);
    check_p("midrst", 0, 0, 0, 0, 1'b0);
    reset = 1'b0;
    #1;
    chk("midrst_in_ready_release", in_ready, 1);
    run_job("post_rst", 8192, 4096, -16384, 12288, 16384, -8192, 8192, 16384,
            10240, 0, -10240, 20480, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
